// File: rtl/index_release_decoder_if.sv
// Release-request handshake: a transfer occurs on a cycle where in_valid and in_ready are both high.
// in_index must be held stable while in_valid is high and the transfer has not yet occurred.
interface index_release_decoder_if #(
    parameter int N = 5
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_index;

    modport master (output in_valid, output in_index, input in_ready);
    modport slave  (input in_valid, input in_index, output in_ready);
endinterface

// File: rtl/index_release_decoder.sv
// Decodes released slot indices to one-hot pulses and accumulates them in a pending mask
// with an incrementally tracked population count and sticky range/duplicate error flags.
module index_release_decoder #(
    parameter int M = 32,
    parameter int N = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    index_release_decoder_if.slave  rel,
    input  logic [M-1:0]            clr,
    output logic                    dec_valid,
    output logic [M-1:0]            dec_onehot,
    output logic [M-1:0]            pending,
    output logic                    any_pending,
    output logic [N:0]              pending_cnt,
    output logic                    range_err,
    output logic                    dup_err
);

    if ((2 ** N) < M) begin : g_bad_params
        $error("index_release_decoder: 2**N must be >= M");
    end

    localparam logic [N:0]   M_LIM = (N + 1)'(M);
    localparam logic [M-1:0] ONE   = M'(1);

    function automatic logic [N:0] popcount(input logic [M-1:0] v);
        logic [N:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            c = c + {{N{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic         acc;
    logic         in_range;
    logic         legal;
    logic [M-1:0] set_vec;
    logic [M-1:0] kept;
    logic [M-1:0] cleared;
    logic         dup;
    logic         new_bit;
    logic [N:0]   cnt_n;

    assign rel.in_ready = rst_n & ~flush;
    assign any_pending  = |pending;

    always_comb begin
        acc      = rel.in_valid & rel.in_ready;
        in_range = {1'b0, rel.in_index} < M_LIM;
        legal    = acc & in_range;
        set_vec  = legal ? (ONE << rel.in_index) : '0;
        kept     = pending & ~clr;
        cleared  = pending & clr;
        // A bit cleared and set in the same cycle is a fresh entry, so only surviving bits count as duplicates.
        dup      = |(set_vec & kept);
        new_bit  = |(set_vec & ~kept);
        cnt_n    = pending_cnt - popcount(cleared) + {{N{1'b0}}, new_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
            dec_valid   <= 1'b0;
            dec_onehot  <= '0;
            range_err   <= 1'b0;
            dup_err     <= 1'b0;
        end else if (flush) begin
            pending     <= '0;
            pending_cnt <= '0;
            dec_valid   <= 1'b0;
            dec_onehot  <= '0;
        end else begin
            pending     <= kept | set_vec;
            pending_cnt <= cnt_n;
            dec_valid   <= legal;
            dec_onehot  <= set_vec;
            if (acc && !in_range) range_err <= 1'b1;
            if (dup)              dup_err   <= 1'b1;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dec_onehot));
    a_valid:  assert property (@(posedge clk) disable iff (!rst_n) dec_valid == (|dec_onehot));
    a_count:  assert property (@(posedge clk) disable iff (!rst_n) 32'(pending_cnt) == $countones(pending));

endmodule

// File: tb/tb_index_release_decoder.sv
// Directed and soak stimulus for index_release_decoder (M=32 and M=20 instances side by side),
// checked against a reference model through per-instance expected queues.
module tb_index_release_decoder;

    typedef struct packed {
        logic        dv;
        logic [31:0] oh;
        logic [31:0] pend;
        logic [5:0]  cnt;
        logic        rerr;
        logic        derr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] clr = '0;
    logic [19:0] clr20;

    logic        dv32, dv20;
    logic [31:0] oh32, pend32;
    logic [19:0] oh20, pend20;
    logic        any32, any20;
    logic [5:0]  cnt32, cnt20;
    logic        rerr32, rerr20, derr32, derr20;

    int n_chk = 0;
    int n_fail = 0;

    exp_t exp_q[$];
    exp_t exp20_q[$];

    logic [31:0] m_pend [2];
    logic        m_rerr [2];
    logic        m_derr [2];

    index_release_decoder_if #(.N(5)) rel32 ();
    index_release_decoder_if #(.N(5)) rel20 ();

    assign clr20 = clr[19:0];

    index_release_decoder #(.M(32), .N(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rel(rel32), .clr(clr),
        .dec_valid(dv32), .dec_onehot(oh32), .pending(pend32), .any_pending(any32),
        .pending_cnt(cnt32), .range_err(rerr32), .dup_err(derr32)
    );

    index_release_decoder #(.M(20), .N(5)) dut20 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rel(rel20), .clr(clr20),
        .dec_valid(dv20), .dec_onehot(oh20), .pending(pend20), .any_pending(any20),
        .pending_cnt(cnt20), .range_err(rerr20), .dup_err(derr20)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0;
            m_rerr[k] = 1'b0;
            m_derr[k] = 1'b0;
        end
    endtask

    // Reference model: computes next state for both instances and queues the expected outputs.
    task automatic model_step(input logic v, input logic [4:0] idx, input logic [31:0] c, input logic f);
        logic [31:0] mask, kept, set, one;
        logic        acc, legal;
        int          lim;
        exp_t        e;
        one = 32'd1;
        for (int k = 0; k < 2; k++) begin
            lim  = (k == 0) ? 32 : 20;
            mask = (k == 0) ? 32'hFFFF_FFFF : 32'h000F_FFFF;
            acc  = v & ~f;
            e    = '0;
            if (f) begin
                m_pend[k] = '0;
            end else begin
                legal = acc && (int'(idx) < lim);
                kept  = m_pend[k] & ~(c & mask);
                set   = legal ? (one << idx) : 32'h0;
                if (legal && kept[idx]) m_derr[k] = 1'b1;
                if (acc && int'(idx) >= lim) m_rerr[k] = 1'b1;
                m_pend[k] = kept | set;
                e.dv = legal;
                e.oh = set;
            end
            e.pend = m_pend[k];
            e.cnt  = 6'($countones(m_pend[k]));
            e.rerr = m_rerr[k];
            e.derr = m_derr[k];
            if (k == 0) exp_q.push_back(e);
            else        exp20_q.push_back(e);
        end
    endtask

    // Driver: applies one cycle of stimulus, checks in_ready, queues expectations, advances one edge.
    task automatic step(input logic v, input logic [4:0] idx, input logic [31:0] c, input logic f);
        rel32.in_valid = v;
        rel32.in_index = idx;
        rel20.in_valid = v;
        rel20.in_index = idx;
        clr   = c;
        flush = f;
        #1;
        chk("in_ready_m32", {63'd0, rel32.in_ready}, {63'd0, ~f});
        chk("in_ready_m20", {63'd0, rel20.in_ready}, {63'd0, ~f});
        model_step(v, idx, c, f);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUTs present outputs, pop and compare the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m32_dec_valid",   {63'd0, dv32},   {63'd0, e.dv});
                chk("m32_dec_onehot",  {32'd0, oh32},   {32'd0, e.oh});
                chk("m32_pending",     {32'd0, pend32}, {32'd0, e.pend});
                chk("m32_any_pending", {63'd0, any32},  {63'd0, |e.pend});
                chk("m32_pending_cnt", {58'd0, cnt32},  {58'd0, e.cnt});
                chk("m32_range_err",   {63'd0, rerr32}, {63'd0, e.rerr});
                chk("m32_dup_err",     {63'd0, derr32}, {63'd0, e.derr});
            end
            if (exp20_q.size() > 0) begin
                e = exp20_q.pop_front();
                chk("m20_dec_valid",   {63'd0, dv20},   {63'd0, e.dv});
                chk("m20_dec_onehot",  {44'd0, oh20},   {32'd0, e.oh});
                chk("m20_pending",     {44'd0, pend20}, {32'd0, e.pend});
                chk("m20_any_pending", {63'd0, any20},  {63'd0, |e.pend});
                chk("m20_pending_cnt", {58'd0, cnt20},  {58'd0, e.cnt});
                chk("m20_range_err",   {63'd0, rerr20}, {63'd0, e.rerr});
                chk("m20_dup_err",     {63'd0, derr20}, {63'd0, e.derr});
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pend"},  {32'd0, pend32}, 64'd0);
        chk({tag, "_cnt"},   {58'd0, cnt32},  64'd0);
        chk({tag, "_dv"},    {63'd0, dv32},   64'd0);
        chk({tag, "_oh"},    {32'd0, oh32},   64'd0);
        chk({tag, "_errs"},  {62'd0, rerr32, derr32}, 64'd0);
        chk({tag, "_ready"}, {63'd0, rel32.in_ready}, 64'd0);
        chk({tag, "_m20"},   {20'd0, pend20, oh20, dv20, rerr20, derr20, any20}, 64'd0);
    endtask

    initial begin
        rel32.in_valid = 1'b0;
        rel32.in_index = '0;
        rel20.in_valid = 1'b0;
        rel20.in_index = '0;
        model_reset();

        // Reset held from time 0
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_initial");
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted in the middle of an accepting cycle
        step(1'b1, 5'd3, 32'h0, 1'b0);
        chk("pre_reset_pend", {32'd0, pend32}, 64'h8);
        rel32.in_valid = 1'b1;
        rel32.in_index = 5'd9;
        rel20.in_valid = 1'b1;
        rel20.in_index = 5'd9;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        rel32.in_valid = 1'b0;
        rel20.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);
        chk("idle_after_reset", {32'd0, pend32}, 64'd0);

        // Basic accept of index 5
        step(1'b1, 5'd5, 32'h0, 1'b0);
        chk("basic_pend",   {32'd0, pend32}, 64'h20);
        chk("basic_onehot", {32'd0, oh32},   64'h20);
        chk("basic_cnt",    {58'd0, cnt32},  64'd1);
        chk("basic_dv",     {63'd0, dv32},   64'd1);
        step(1'b0, 5'd0, 32'h0, 1'b0);
        chk("basic_dv_drop", {63'd0, dv32}, 64'd0);

        // Same bit set and cleared together, then a true duplicate
        step(1'b1, 5'd5, 32'h20, 1'b0);
        chk("setclr_pend", {32'd0, pend32}, 64'h20);
        chk("setclr_cnt",  {58'd0, cnt32},  64'd1);
        chk("setclr_dup",  {63'd0, derr32}, 64'd0);
        step(1'b1, 5'd5, 32'h0, 1'b0);
        chk("dup_flag", {63'd0, derr32}, 64'd1);
        chk("dup_pend", {32'd0, pend32}, 64'h20);
        chk("dup_cnt",  {58'd0, cnt32},  64'd1);
        chk("dup_dv",   {63'd0, dv32},   64'd1);

        // Multi-clear plus set
        step(1'b0, 5'd0, 32'h20, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 32'h0, 1'b0);
        chk("pre_multi_pend", {32'd0, pend32}, 64'h0F);
        step(1'b1, 5'd31, 32'h0000_0105, 1'b0);
        chk("multi_pend", {32'd0, pend32}, 64'h8000_000A);
        chk("multi_cnt",  {58'd0, cnt32},  64'd3);

        // Out-of-range index on the M=20 instance
        step(1'b1, 5'd25, 32'h0, 1'b0);
        chk("range_err_m20", {63'd0, rerr20}, 64'd1);
        chk("range_dv_m20",  {63'd0, dv20},   64'd0);
        chk("range_pend_m20", {44'd0, pend20}, 64'h0000A);
        chk("range_err_m32", {63'd0, rerr32}, 64'd0);

        // Fill all slots, then flush with a request present
        step(1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 32'h0, 1'b0);
        chk("full_cnt",  {58'd0, cnt32},  64'd32);
        chk("full_pend", {32'd0, pend32}, 64'hFFFF_FFFF);
        chk("full_cnt_m20", {58'd0, cnt20}, 64'd20);
        step(1'b1, 5'd7, 32'h0, 1'b1);
        chk("flush_pend", {32'd0, pend32}, 64'd0);
        chk("flush_cnt",  {58'd0, cnt32},  64'd0);
        chk("flush_errs", {62'd0, rerr32, derr32}, 64'd1);

        // Random soak
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 $urandom & $urandom & $urandom, $urandom_range(0, 19) == 0);
        end
        step(1'b0, 5'd0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drain", 64'(exp_q.size() + exp20_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
